lsu_agu: RTL and testbench

Load/store address-generation and data-memory access unit for the EX/MEM boundary of the pipelined core. Consumes the sign-extended 32-bit immediate and register read data and forms the effective address `base + simm`. It then runs one data-memory transaction per accepted request over a req/ack handshake and returns aligned, extended load data. It stalls the pipeline while a transaction is outstanding.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_lane_align.sv | 46 ++++
 rtl/lsu_agu.sv | 181 ++++++++++++++++++
 tb/tb_lsu_agu.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store address-generation unit.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Byte-lane enables for an access of size sz at byte offset off.
  function automatic logic [3:0] be_for(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_B:    be_for = 4'b0001 << off;
      SZ_H:    be_for = off[1] ? 4'b1100 : 4'b0011;
      SZ_W:    be_for = 4'b1111;
      default: be_for = 4'b0000;
    endcase
  endfunction

  // True when the size code is legal and the offset is naturally aligned.
  function automatic logic is_legal(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_B:    is_legal = 1'b1;
      SZ_H:    is_legal = ~off[0];
      SZ_W:    is_legal = (off == 2'b00);
      default: is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store data/byte enables out, load data in.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] st_wdata_in,
  input  logic [1:0]  st_off,
  input  logic [1:0]  st_size,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  input  logic [31:0] ld_rdata,
  input  logic [1:0]  ld_off,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: replicate the narrow datum across every lane it may land in.
  always_comb begin
    st_be = be_for(st_size, st_off);
    case (st_size)
      SZ_B:    st_wdata = {4{st_wdata_in[7:0]}};
      SZ_H:    st_wdata = {2{st_wdata_in[15:0]}};
      default: st_wdata = st_wdata_in;
    endcase
  end

  // Load side: pick the addressed lane, then sign- or zero-extend it.
  always_comb begin
    case (ld_off)
      2'd0:    ld_byte = ld_rdata[7:0];
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
    ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_size)
      SZ_B:    ld_data = {{24{ld_byte[7] & ~ld_unsigned}}, ld_byte};
      SZ_H:    ld_data = {{16{ld_half[15] & ~ld_unsigned}}, ld_half};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_agu.sv
// EX/MEM load/store unit: effective-address adder, memory req/ack FSM,
// timeout counter and registered response.
//
// Handshakes: a request is accepted on a rising edge where req_valid and
// req_ready are both high (req_ready is high only in IDLE). The memory side
// holds mem_req and all mem_* fields stable until a rising edge where
// mem_req and mem_ack are both high, or until the timeout expires.
// rsp_valid is a single-cycle pulse with no back-pressure.
module lsu_agu
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] base,
  input  logic [31:0] simm,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic        uns_q, uns_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic [31:0] ea;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] ld_data;

  assign ea = base + simm;

  lsu_lane_align u_align (
    .st_wdata_in (wdata),
    .st_off      (ea[1:0]),
    .st_size     (size),
    .st_wdata    (st_wdata),
    .st_be       (st_be),
    .ld_rdata    (mem_rdata),
    .ld_off      (off_q),
    .ld_size     (size_q),
    .ld_unsigned (uns_q),
    .ld_data     (ld_data)
  );

  // Next-state and registered-output logic for IDLE -> REQ -> RESP.
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    off_d       = off_q;
    uns_d       = uns_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          size_d      = size;
          off_d       = ea[1:0];
          uns_d       = unsigned_ld;
          cnt_d       = 16'd0;
          mem_we_d    = is_store;
          mem_addr_d  = {ea[31:2], 2'b00};
          mem_be_d    = st_be;
          mem_wdata_d = st_wdata;
          if (is_legal(size, ea[1:0])) begin
            state_d   = ST_REQ;
            mem_req_d = 1'b1;
          end else begin
            // Bad size or alignment: answer directly, never touch memory.
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = 32'd0;
          end
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          state_d     = ST_RESP;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = mem_we_q ? 32'd0 : ld_data;
        end else if (cnt_q == TO_LAST) begin
          state_d     = ST_RESP;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = 32'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      uns_q       <= 1'b0;
      cnt_q       <= 16'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      off_q       <= off_d;
      uns_q       <= uns_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign stall     = ((state_q == ST_IDLE) & req_valid) | (state_q == ST_REQ);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_agu.sv
// Bench for lsu_agu: cycle schedule derived from the timing rules, per-cycle
// output checks and a response scoreboard.
module tb_lsu_agu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        is_store = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        unsigned_ld = 1'b0;
  logic [31:0] base = 32'd0;
  logic [31:0] simm = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  lsu_agu #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .is_store(is_store), .size(size), .unsigned_ld(unsigned_ld),
    .base(base), .simm(simm), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- counters and expectations ----------------
  int total = 0;
  int bad   = 0;
  logic        chk_en = 1'b0;
  logic        exp_ready, exp_stall, exp_mem_req, exp_rsp_valid, exp_zero;
  logic        exp_we;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_be;
  logic [32:0] exp_q[$];   // {err, data} per expected response

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic m_legal(input logic [1:0] sz, input logic [31:0] ea);
    if (sz == 2'd0) return 1'b1;
    if (sz == 2'd1) return (ea % 2) == 0;
    if (sz == 2'd2) return (ea % 4) == 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] ea);
    int k = int'(ea % 4);
    if (sz == 2'd0) return 4'(1 << k);
    if (sz == 2'd1) return (k >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return (wd % 256) * 32'h01010101;
    if (sz == 2'd1) return (wd % 65536) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                         input logic [31:0] ea, input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * (ea % 4));
    if (sz == 2'd0) begin
      v = v % 256;
      if (!uns && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  // ---------------- per-cycle compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
      chk("stall", {31'd0, stall}, {31'd0, exp_stall});
      chk("mem_req", {31'd0, mem_req}, {31'd0, exp_mem_req});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_rsp_valid});
      if (exp_mem_req) begin
        chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_be", {28'd0, mem_be}, {28'd0, exp_be});
        chk("mem_wdata", mem_wdata, exp_wdata);
      end
      if (exp_zero) begin
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      end
      if (rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response at %0t", $time);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
          chk("rsp_data", rsp_data, e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic rdy, input logic stl, input logic mreq,
                         input logic rv, input logic zero);
    exp_ready = rdy; exp_stall = stl; exp_mem_req = mreq;
    exp_rsp_valid = rv; exp_zero = zero;
  endtask

  task automatic idle(input int n, input logic zero);
    req_valid = 1'b0;
    mem_ack = 1'b0;
    for (int i = 0; i < n; i++) begin
      set_exp(1'b1, 1'b0, 1'b0, 1'b0, zero);
      next_cycle();
    end
  endtask

  // One transaction; ack_at < 0 or >= TO means the memory never answers.
  task automatic txn(input logic st, input logic [1:0] sz, input logic uns,
                     input logic [31:0] b, input logic [31:0] s, input logic [31:0] wd,
                     input logic [31:0] rd, input int ack_at);
    logic [31:0] ea;
    logic        tmo;
    ea  = b + s;
    tmo = (ack_at < 0) || (ack_at >= TO);
    req_valid = 1'b1; is_store = st; size = sz; unsigned_ld = uns;
    base = b; simm = s; wdata = wd; mem_ack = 1'b0;
    set_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle();
    // Inputs are scrambled once accepted; the unit must not care.
    is_store = 1'($urandom); size = 2'($urandom); unsigned_ld = 1'($urandom);
    base = $urandom; simm = $urandom; wdata = $urandom;
    if (!m_legal(sz, ea)) begin
      req_valid = 1'($urandom);
      exp_q.push_back({1'b1, 32'd0});
      set_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      next_cycle();
    end else begin
      exp_we = st; exp_addr = (ea / 4) * 4; exp_be = m_be(sz, ea);
      exp_wdata = m_wdata(sz, wd);
      for (int i = 0; i < (tmo ? TO : ack_at + 1); i++) begin
        req_valid = 1'($urandom);
        mem_ack   = (!tmo && i == ack_at);
        mem_rdata = mem_ack ? rd : $urandom;
        set_exp(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle();
      end
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      req_valid = 1'($urandom);
      if (tmo) exp_q.push_back({1'b1, 32'd0});
      else     exp_q.push_back({1'b0, st ? 32'd0 : m_load(sz, uns, ea, rd)});
      set_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      next_cycle();
    end
    req_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    idle(2, 1'b1);

    // Hand-computed pins on the model itself.
    chk("pin_lw_addr", ((32'h1000 + 32'hFFFFFFFC) / 4) * 4, 32'h00000FFC);
    chk("pin_lb_signed", m_load(2'd0, 1'b0, 32'h2003, 32'h80112233), 32'hFFFFFF80);
    chk("pin_lb_unsigned", m_load(2'd0, 1'b1, 32'h2003, 32'h80112233), 32'h00000080);
    chk("pin_lb_be", {28'd0, m_be(2'd0, 32'h2003)}, 32'h8);
    chk("pin_sh_wdata", m_wdata(2'd1, 32'h0000ABCD), 32'hABCDABCD);
    chk("pin_sh_be", {28'd0, m_be(2'd1, 32'h12)}, 32'hC);
    chk("pin_wrap_addr", ((32'hFFFFFFFC + 32'd8) / 4) * 4, 32'h00000004);
    chk("pin_lh_signed", m_load(2'd1, 1'b0, 32'h2, 32'h8001_1234), 32'hFFFF8001);

    // Directed cases.
    txn(1'b0, 2'd2, 1'b0, 32'h1000, 32'hFFFFFFFC, 32'h0, 32'hDEADBEEF, 0);
    idle(1, 1'b0);
    txn(1'b0, 2'd0, 1'b0, 32'h2000, 32'h3, 32'h0, 32'h80112233, 1);
    txn(1'b0, 2'd0, 1'b1, 32'h2000, 32'h3, 32'h0, 32'h80112233, 0);
    txn(1'b1, 2'd1, 1'b0, 32'h10, 32'h2, 32'h0000ABCD, 32'h5555AAAA, 3);
    txn(1'b0, 2'd2, 1'b0, 32'h0, 32'h6, 32'h0, 32'h12345678, 0);
    txn(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 32'h12345678, 0);
    txn(1'b0, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h8, 32'h0, 32'h0, -1);
    txn(1'b1, 2'd0, 1'b0, 32'h7, 32'h0, 32'h000000A5, 32'h0, 2);
    idle(1, 1'b0);

    // Reset in the second REQ cycle, then a stray ack.
    req_valid = 1'b1; is_store = 1'b0; size = 2'd2; unsigned_ld = 1'b0;
    base = 32'h40; simm = 32'h0; wdata = 32'h0;
    set_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle();
    req_valid = 1'b0;
    exp_we = 1'b0; exp_addr = 32'h40; exp_be = 4'hF; exp_wdata = 32'h0;
    set_exp(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    next_cycle();
    idle(2, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] b, s;
      int ack_at;
      b = $urandom;
      if ($urandom_range(0, 2) != 0) b[1:0] = 2'b00;
      s = 32'($urandom_range(0, 64)) - 32'd32;
      ack_at = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TO - 1));
      txn(1'($urandom), ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
          1'($urandom), b, s, $urandom, $urandom, ack_at);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2), 1'b0);
    end
    idle(2, 1'b0);

    // ---------------- final report ----------------
    chk("leftover_responses", exp_q.size(), 32'd0);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
